// File: rtl/regfile_alu_pipe.sv
// -----------------------------------------------------------------------------
// regfile_alu_pipe
//
// A register file with one ALU stage in front of it. Each issued operation
// reads two operands, computes one result and registers it. One cycle later
// the registered result is written back into the register file. A bypass
// path lets back-to-back dependent operations see the result that has not
// been written yet, so an operation can be issued on every cycle with no
// stall.
//
// Parameters
//   WIDTH : data, register and immediate width in bits (>= 4)
//   DEPTH : number of registers (power of two, >= 4); AW = log2(DEPTH)
//
// Ports
//   CLK          : clock; all state updates on the rising edge
//   RST          : asynchronous, active-high reset
//   in_valid     : an operation is issued this cycle
//   RA1, RA2     : operand read addresses
//   WA           : destination register address
//   write_enable : commit the result to WA
//   ALUSrc       : 1 = immediate is operand B, 0 = register[RA2]
//   ALUControl   : 000 AND, 001 OR, 010 ADD, 011 XOR,
//                  100 SLL, 101 SRL, 110 SUB, 111 SLT (unsigned)
//   immediate    : immediate operand
//   out_valid    : ALUResult, the flags and cpu_out hold a new result
//   ALUResult    : registered ALU result
//   cpu_out      : registered operand A, taken after the bypass
//   Zero, Carry, Negative, Overflow : registered flags
// -----------------------------------------------------------------------------
module regfile_alu_pipe #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   input  logic [AW-1:0]    RA1,
   input  logic [AW-1:0]    RA2,
   input  logic [AW-1:0]    WA,
   input  logic             write_enable,
   input  logic             ALUSrc,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] immediate,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] cpu_out,
   output logic             Zero,
   output logic             Carry,
   output logic             Negative,
   output logic             Overflow
);

   // Shift amount uses only the low log2(WIDTH) bits of operand B.
   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // Returns {overflow, carry, result}.
   // Signed overflow is detected by computing the sum/difference one bit
   // wider in two's complement and checking whether it still equals the
   // sign extension of the truncated WIDTH-bit result.
   function automatic logic [WIDTH+1:0] alu_eval(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic        [WIDTH:0]   usum;
      logic signed [WIDTH:0]   ssum;
      logic signed [WIDTH:0]   sdiff;
      logic        [WIDTH-1:0] res;
      logic                    c;
      logic                    v;
      usum  = {1'b0, a} + {1'b0, b};
      ssum  = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
      sdiff = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
      res   = '0;
      c     = 1'b0;
      v     = 1'b0;
      case (op)
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_ADD: begin
            res = usum[WIDTH-1:0];
            c   = usum[WIDTH];
            v   = (ssum != $signed({res[WIDTH-1], res}));
         end
         OP_SUB: begin
            res = a - b;
            c   = (a >= b);
            v   = (sdiff != $signed({res[WIDTH-1], res}));
         end
         OP_SLL: res = a << b[SW-1:0];
         OP_SRL: res = a >> b[SW-1:0];
         OP_SLT: res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: res = '0;
      endcase
      return {v, c, res};
   endfunction

   logic [WIDTH-1:0] regs [DEPTH];

   logic             vld_p1;
   logic [WIDTH-1:0] res_p1;
   logic [WIDTH-1:0] opa_p1;
   logic             zero_p1;
   logic             carry_p1;
   logic             neg_p1;
   logic             ovf_p1;
   logic [AW-1:0]    wa_p1;
   logic             we_p1;

   logic             wb_p1;
   logic [WIDTH-1:0] opa_p0;
   logic [WIDTH-1:0] opb_reg_p0;
   logic [WIDTH-1:0] opb_p0;
   logic [WIDTH+1:0] alu_p0;

   // ---- Stage 0: operand read with bypass, ALU ----
   // A registered result is still in flight to the file whenever it is valid,
   // enabled and not aimed at register 0; reads of that address take it
   // instead of the stale file contents.
   assign wb_p1 = vld_p1 && we_p1 && (wa_p1 != '0);

   always_comb begin
      opa_p0     = '0;
      opb_reg_p0 = '0;
      if (RA1 != '0) begin
         opa_p0 = (wb_p1 && (RA1 == wa_p1)) ? res_p1 : regs[RA1];
      end
      if (RA2 != '0) begin
         opb_reg_p0 = (wb_p1 && (RA2 == wa_p1)) ? res_p1 : regs[RA2];
      end
      opb_p0 = ALUSrc ? immediate : opb_reg_p0;
      alu_p0 = alu_eval(ALUControl, opa_p0, opb_p0);
   end

   // ---- Stage 1: result register ----
   // Data registers only load on an issue so outputs hold across idle cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_p1   <= 1'b0;
         res_p1   <= '0;
         opa_p1   <= '0;
         zero_p1  <= 1'b0;
         carry_p1 <= 1'b0;
         neg_p1   <= 1'b0;
         ovf_p1   <= 1'b0;
         wa_p1    <= '0;
         we_p1    <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            res_p1   <= alu_p0[WIDTH-1:0];
            opa_p1   <= opa_p0;
            zero_p1  <= (alu_p0[WIDTH-1:0] == '0);
            carry_p1 <= alu_p0[WIDTH];
            neg_p1   <= alu_p0[WIDTH-1];
            ovf_p1   <= alu_p0[WIDTH+1];
            wa_p1    <= WA;
            we_p1    <= write_enable;
         end
      end
   end

   // ---- Stage 2: register file write-back ----
   // Reset clears the file and drops any write still in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_p1) begin
         regs[wa_p1] <= res_p1;
      end
   end

   assign out_valid = vld_p1;
   assign ALUResult = res_p1;
   assign cpu_out   = opa_p1;
   assign Zero      = zero_p1;
   assign Carry     = carry_p1;
   assign Negative  = neg_p1;
   assign Overflow  = ovf_p1;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_regfile_alu_pipe
//
// Scoreboard bench for regfile_alu_pipe. The stimulus process computes each
// expected response from an architectural model (registers updated in issue
// order, plain integer arithmetic) and queues it; a monitor process pops and
// compares whenever out_valid is seen. A second, wider instance covers the
// WIDTH=16 / DEPTH=32 case.
// -----------------------------------------------------------------------------
module tb_regfile_alu_pipe;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   // 8-bit / 16-entry instance
   logic       in_valid = 1'b0;
   logic [3:0] RA1 = '0, RA2 = '0, WA = '0;
   logic       write_enable = 1'b0, ALUSrc = 1'b0;
   logic [2:0] ALUControl = '0;
   logic [7:0] immediate = '0;
   logic       out_valid;
   logic [7:0] ALUResult, cpu_out;
   logic       Zero, Carry, Negative, Overflow;

   regfile_alu_pipe #(.WIDTH(8), .DEPTH(16)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .RA1(RA1), .RA2(RA2), .WA(WA),
      .write_enable(write_enable), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
      .immediate(immediate), .out_valid(out_valid), .ALUResult(ALUResult),
      .cpu_out(cpu_out), .Zero(Zero), .Carry(Carry), .Negative(Negative),
      .Overflow(Overflow)
   );

   // 16-bit / 32-entry instance
   logic        w_in_valid = 1'b0;
   logic [4:0]  w_RA1 = '0, w_RA2 = '0, w_WA = '0;
   logic        w_write_enable = 1'b0, w_ALUSrc = 1'b0;
   logic [2:0]  w_ALUControl = '0;
   logic [15:0] w_immediate = '0;
   logic        w_out_valid;
   logic [15:0] w_ALUResult, w_cpu_out;
   logic        w_Zero, w_Carry, w_Negative, w_Overflow;

   regfile_alu_pipe #(.WIDTH(16), .DEPTH(32)) dut_w (
      .CLK(CLK), .RST(RST), .in_valid(w_in_valid), .RA1(w_RA1), .RA2(w_RA2),
      .WA(w_WA), .write_enable(w_write_enable), .ALUSrc(w_ALUSrc),
      .ALUControl(w_ALUControl), .immediate(w_immediate),
      .out_valid(w_out_valid), .ALUResult(w_ALUResult), .cpu_out(w_cpu_out),
      .Zero(w_Zero), .Carry(w_Carry), .Negative(w_Negative),
      .Overflow(w_Overflow)
   );

   typedef struct {
      int res;
      int opa;
      bit z;
      bit c;
      bit n;
      bit v;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   model_rf[16];
   int   vectors     = 0;
   int   miscompares = 0;
   int   last_res    = 0;

   function automatic void chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Architectural reference: 8-bit ALU from plain integer arithmetic.
   function automatic exp_t ref_op(int op, int a, int b);
      exp_t e;
      int   sa, sb, r;
      sa  = (a >= 128) ? a - 256 : a;
      sb  = (b >= 128) ? b - 256 : b;
      e.c = 1'b0;
      e.v = 1'b0;
      r   = 0;
      case (op)
         0: r = a & b;
         1: r = a | b;
         3: r = a ^ b;
         2: begin
            r   = (a + b) % 256;
            e.c = ((a + b) > 255);
            e.v = ((sa + sb) > 127) || ((sa + sb) < -128);
         end
         6: begin
            r   = (a - b + 256) % 256;
            e.c = (a >= b);
            e.v = ((sa - sb) > 127) || ((sa - sb) < -128);
         end
         4: r = (a << (b % 8)) % 256;
         5: r = a >> (b % 8);
         7: r = (a < b) ? 1 : 0;
         default: r = 0;
      endcase
      e.res = r;
      e.opa = a;
      e.z   = (r == 0);
      e.n   = (r >= 128);
      return e;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model_rf[i] = 0;
   endfunction

   // Drive one issue for one cycle; called back to back for consecutive issues.
   task automatic issue(int op, int ra1, int ra2, int wa, bit we, bit src, int imm);
      exp_t e;
      int   a, b;
      a = model_rf[ra1];
      b = src ? imm : model_rf[ra2];
      e = ref_op(op, a, b);
      sb_q.push_back(e);
      if (we && wa != 0) model_rf[wa] = e.res;
      in_valid     = 1'b1;
      ALUControl   = 3'(op);
      RA1          = 4'(ra1);
      RA2          = 4'(ra2);
      WA           = 4'(wa);
      write_enable = we;
      ALUSrc       = src;
      immediate    = 8'(imm);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Monitor: compare every presented result; across idle cycles the
   // outputs must hold the last result.
   initial begin
      forever begin
         @(negedge CLK);
         if (RST) continue;
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_out_valid: got result 0x%0h, expected no output", ALUResult);
            end else begin
               mon_e = sb_q.pop_front();
               chk("ALUResult", int'(ALUResult), mon_e.res);
               chk("cpu_out",   int'(cpu_out),   mon_e.opa);
               chk("Zero",      int'(Zero),      int'(mon_e.z));
               chk("Carry",     int'(Carry),     int'(mon_e.c));
               chk("Negative",  int'(Negative),  int'(mon_e.n));
               chk("Overflow",  int'(Overflow),  int'(mon_e.v));
               last_res = mon_e.res;
            end
         end else begin
            chk("hold_ALUResult", int'(ALUResult), last_res);
         end
      end
   end

   initial begin
      model_clear();
      // Reset is asynchronous: outputs must clear before any clock edge.
      #1 RST = 1'b1;
      #2;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_ALUResult", int'(ALUResult), 0);
      chk("rst_cpu_out",   int'(cpu_out),   0);
      chk("rst_flags",     int'({Zero, Carry, Negative, Overflow}), 0);
      chk("rst_w_ALUResult", int'(w_ALUResult), 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST = 1'b0;

      // Every register reads 0 after reset.
      for (int i = 0; i < 16; i++) issue(2, i, 0, 0, 0, 1, 0);
      idle(2);

      // Dependent pair through the bypass, then a read from the file.
      issue(2, 0, 0, 1, 1, 1, 5);
      issue(2, 1, 0, 2, 1, 1, 3);
      idle(3);
      issue(2, 2, 0, 3, 0, 1, 0);
      idle(1);

      // Writes to r0 are dropped, including on the bypass path.
      issue(2, 0, 0, 0, 1, 1, 9);
      issue(2, 0, 0, 3, 0, 1, 0);
      idle(2);
      issue(2, 0, 0, 3, 0, 1, 0);
      idle(1);

      // Flag corner cases.
      issue(2, 0, 0, 1, 1, 1, 3);
      issue(6, 1, 0, 6, 1, 1, 5);       // 3-5 = 0xFE, C=0, N=1
      issue(2, 0, 0, 2, 1, 1, 'h7F);
      issue(2, 2, 0, 7, 0, 1, 1);       // 0x80, V=1
      issue(2, 0, 0, 3, 1, 1, 'hFF);
      issue(2, 3, 0, 7, 0, 1, 1);       // 0x00, C=1, Z=1
      issue(2, 0, 0, 5, 1, 1, 'h81);
      issue(4, 5, 0, 7, 0, 1, 1);       // 0x02
      issue(6, 2, 2, 8, 1, 0, 0);       // equal SUB: C=1, Z=1
      issue(6, 2, 3, 9, 1, 0, 0);       // 0x7F-0xFF
      issue(7, 6, 2, 10, 1, 0, 0);      // SLT unsigned
      idle(2);

      // Randomized traffic with gaps.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
         issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1),
               int'($urandom_range(0, 255)));
      end
      idle(3);

      // Wide instance: write 0xBEEF to r31, read it via bypass and from file.
      w_in_valid = 1'b1; w_ALUControl = 3'b010; w_RA1 = 5'd0; w_WA = 5'd31;
      w_write_enable = 1'b1; w_ALUSrc = 1'b1; w_immediate = 16'hBEEF;
      @(posedge CLK); #1;
      w_RA1 = 5'd31; w_WA = 5'd0; w_write_enable = 1'b0; w_immediate = 16'h0000;
      @(negedge CLK);
      chk("w_wr_valid",   int'(w_out_valid), 1);
      chk("w_wr_result",  int'(w_ALUResult), 'hBEEF);
      chk("w_wr_cpu_out", int'(w_cpu_out),   0);
      @(posedge CLK); #1;
      w_in_valid = 1'b0;
      @(negedge CLK);
      chk("w_byp_valid",    int'(w_out_valid), 1);
      chk("w_byp_result",   int'(w_ALUResult), 'hBEEF);
      chk("w_byp_cpu_out",  int'(w_cpu_out),   'hBEEF);
      chk("w_byp_negative", int'(w_Negative),  1);
      chk("w_byp_zcv",      int'({w_Zero, w_Carry, w_Overflow}), 0);
      idle(2);
      w_in_valid = 1'b1;
      @(posedge CLK); #1;
      w_in_valid = 1'b0;
      @(negedge CLK);
      chk("w_file_result",   int'(w_ALUResult), 'hBEEF);
      chk("w_file_negative", int'(w_Negative),  1);
      idle(1);

      // Reset while a write to r4 is still in flight.
      issue(2, 0, 0, 4, 1, 1, 7);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      last_res = 0;
      model_clear();
      #1;
      chk("rst2_out_valid", int'(out_valid), 0);
      chk("rst2_ALUResult", int'(ALUResult), 0);
      chk("rst2_cpu_out",   int'(cpu_out),   0);
      @(posedge CLK);
      @(negedge CLK) RST = 1'b0;
      issue(2, 4, 0, 0, 0, 1, 0);       // first edge after reset accepts it
      idle(3);
      issue(2, 4, 0, 0, 0, 1, 0);
      idle(3);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data, register and immediate width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of registers (a power of two, at least 4); AW = log2(DEPTH).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is issued this cycle.
REQ-006 SHALL have ports RA1 and RA2, input, AW bits each: operand read addresses.
REQ-007 SHALL have port WA, input, AW bits: destination register address.
REQ-008 SHALL have port write_enable, input, 1 bit: commit the result to WA.
REQ-009 SHALL have port ALUSrc, input, 1 bit: 1 selects immediate as operand B; 0 selects register[RA2].
REQ-010 SHALL have port ALUControl, input, 3 bits: ALU operation select.
REQ-011 SHALL have port immediate, input, WIDTH bits: immediate operand.
REQ-012 SHALL have port out_valid, output, 1 bit: ALUResult, flags and cpu_out hold a new result.
REQ-013 SHALL have port ALUResult, output, WIDTH bits: registered ALU result.
REQ-014 SHALL have port cpu_out, output, WIDTH bits: registered operand A (after bypass).
REQ-015 SHALL have ports Zero, Carry, Negative and Overflow, output, 1 bit each: registered flags.

Function
REQ-016 SHALL implement a DEPTH x WIDTH register file; register 0 SHALL always read as 0 and SHALL ignore writes.
REQ-017 SHALL decode ALUControl as follows: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLL, 101 SRL, 110 SUB (A-B), 111 SLT (unsigned, result 1 or 0).
REQ-018 SLL and SRL SHALL shift by B[log2(WIDTH)-1:0] and SHALL fill with zeros.
REQ-019 Stage 1: when in_valid is high, the block SHALL read operands combinationally, compute the result and register ALUResult, cpu_out, the flags, WA and write_enable on the next edge, and SHALL set out_valid to 1 (latency 1 cycle).
REQ-020 When in_valid is low, out_valid SHALL go to 0 on the next edge; ALUResult, cpu_out and the flags SHALL hold their values.
REQ-021 Stage 2: on the edge after a result is registered, when out_valid=1, the registered write_enable=1 and the registered WA is not 0, the result SHALL be written into the register file.
REQ-022 Bypass: if a stage-1 read address equals a pending stage-2 write address (valid, enabled, non-zero), the operand SHALL be the pending result rather than the stale file value.
REQ-023 An issue SHALL be accepted every cycle; back-to-back dependent operations SHALL see correct values with no stall.
REQ-024 Zero SHALL equal (result == 0); Negative SHALL equal result[WIDTH-1].
REQ-025 Carry SHALL be the carry-out for ADD, 1 when A >= B unsigned for SUB, and 0 for all other operations.
REQ-026 Overflow SHALL be signed overflow for ADD and SUB, and 0 for all other operations.
REQ-027 ADD and SUB results SHALL wrap modulo 2^WIDTH.

Reset
REQ-028 While RST is high, all registers, ALUResult, cpu_out, all flags and out_valid SHALL be 0, independent of CLK.
REQ-029 A pending stage-2 write at the moment of reset SHALL be discarded.
REQ-030 The first issue SHALL be accepted on the first rising edge after RST falls.

Verification (WIDTH=8, DEPTH=16 unless stated)
REQ-031 Reset, then ADD RA1=i with imm 0 for every i -> ALUResult=0 and Zero=1 for all sixteen reads.
REQ-032 Issue r1=r0+5, then next cycle r2=r1+3 -> ALUResult=5, then 8 via bypass; after idle cycles, a read of r2 returns 8.
REQ-033 Issue an ADD to WA=0 with imm 9 -> ALUResult=9 with out_valid=1; a subsequent read of r0 returns 0.
REQ-034 Flag checks:
- r1=3, SUB imm 5 -> ALUResult=0xFE, Carry=0, Negative=1.
- 0x7F ADD 1 -> 0x80, Overflow=1.
- 0xFF ADD 1 -> 0x00, Carry=1, Zero=1.
- SLL 0x81 by 1 -> 0x02.
REQ-035 Issue a write of 7 to r4 and assert RST in the following cycle before the edge -> r4 reads 0 after reset; out_valid=0.
REQ-036 With WIDTH=16 and DEPTH=32: write 0xBEEF to r31, then read with ADD imm 0 -> ALUResult=0xBEEF and Negative=1.
